// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller and its refresh scheduler:
// scheduler state encoding, controller command encodings and default timing.
package sdram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPP  = 2'd1,
    S_URG  = 2'd2
  } refsched_state_t;

  // Command bus encoding {cs_n, ras_n, cas_n, we_n} as driven by the controller
  typedef enum logic [3:0] {
    CMD_LOAD_MODE    = 4'b0000,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_PRECHARGE    = 4'b0010,
    CMD_ACTIVE       = 4'b0011,
    CMD_WRITE        = 4'b0100,
    CMD_READ         = 4'b0101,
    CMD_NOP          = 4'b0111
  } sdram_cmd_t;

  // 7.8 us tREFI at ~128 MHz core clock
  localparam int REFI_CYCLES_DEF   = 1000;
  localparam int MAX_DEBT_DEF      = 8;
  localparam int URGENT_THRESH_DEF = 6;
  localparam int IDLE_WIN_DEF      = 16;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running tREFI-style period timer. Counts 0..PERIOD-1 while enabled and
// emits a one-cycle tick on the wrap. Held at zero while disabled.
module sdram_refresh_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_wrap;

  assign w_wrap = (r_tick_cnt == LAST);

  // Period counter; restarts from zero whenever the scheduler is dormant
  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      r_tick_cnt <= '0;
    end else if (w_wrap) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable & w_wrap;

endmodule

// File: rtl/sdram_refresh_sched.sv
// SDRAM refresh scheduler. Accrues one refresh obligation per tREFI period,
// requests refreshes opportunistically when clients have been quiet, and
// stalls clients once the outstanding debt becomes urgent.
// Optional build macro SDRAM_REFSCHED_STATS_EN adds the ack counter and
// peak-debt statistic; without it both stat outputs are tied to zero.
module sdram_refresh_sched
  import sdram_pkg::*;
#(
  parameter int REFI_CYCLES   = REFI_CYCLES_DEF,
  parameter int MAX_DEBT      = MAX_DEBT_DEF,
  parameter int URGENT_THRESH = URGENT_THRESH_DEF,
  parameter int IDLE_WIN      = IDLE_WIN_DEF,
  localparam int DEBT_W       = $clog2(MAX_DEBT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_client_active,
  input  logic              i_refresh_ack,
  output logic              o_refresh_req,
  output logic              o_hold_clients,
  output logic [DEBT_W-1:0] o_debt,
  output logic              o_overflow,
  output logic [15:0]       o_stat_refresh_count,
  output logic [DEBT_W-1:0] o_stat_max_debt
);

  localparam int IDLE_W = $clog2(IDLE_WIN + 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URGENT_THRESH);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_WIN);

  refsched_state_t   r_state;
  refsched_state_t   w_state_next;
  logic [DEBT_W-1:0] r_debt;
  logic [DEBT_W-1:0] w_debt_next;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_overflow;
  logic              w_overflow_set;
  logic              w_tick;
  logic              w_ack_take;
  logic              w_idle_ok;
  logic              w_urgent;

  sdram_refresh_timer #(
    .PERIOD (REFI_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  // Quiet-cycle counter, saturating at the idle window
  always_ff @(posedge clk) begin
    if (reset || !i_enable || i_client_active) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_FULL) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_idle_ok = (r_idle_cnt == IDLE_FULL);

  // An ack only pays something off when there is debt to pay
  assign w_ack_take = i_enable & i_refresh_ack & (r_debt != '0);

  // Debt accounting: a simultaneous tick and consumed ack cancel out
  always_comb begin
    w_debt_next    = r_debt;
    w_overflow_set = 1'b0;
    if (!i_enable) begin
      w_debt_next = '0;
    end else if (w_tick && !w_ack_take) begin
      if (r_debt == DEBT_MAX) begin
        w_overflow_set = 1'b1;
      end else begin
        w_debt_next = r_debt + 1'b1;
      end
    end else if (w_ack_take && !w_tick) begin
      w_debt_next = r_debt - 1'b1;
    end
  end

  assign w_urgent = (w_debt_next >= DEBT_URG);

  // Debt register and sticky overflow; overflow survives enable toggling
  always_ff @(posedge clk) begin
    if (reset) begin
      r_debt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_debt <= w_debt_next;
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, evaluated on post-update debt so outputs track it
  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_urgent) begin
            w_state_next = S_URG;
          end else if ((w_debt_next != '0) && w_idle_ok) begin
            w_state_next = S_OPP;
          end
        end
        S_OPP: begin
          if (w_urgent) begin
            w_state_next = S_URG;
          end else if (w_debt_next == '0) begin
            w_state_next = S_IDLE;
          end else if (i_client_active) begin
            w_state_next = S_IDLE;
          end
        end
        S_URG: begin
          if (!w_urgent) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    o_refresh_req  = (r_state != S_IDLE);
    o_hold_clients = (r_state == S_URG);
  end

  assign o_debt     = r_debt;
  assign o_overflow = r_overflow;

`ifdef SDRAM_REFSCHED_STATS_EN
  logic [15:0]       r_stat_refresh_count;
  logic [DEBT_W-1:0] r_stat_max_debt;

  // Consumed-ack counter and peak-debt tracker; cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_refresh_count <= '0;
      r_stat_max_debt      <= '0;
    end else begin
      if (w_ack_take) begin
        r_stat_refresh_count <= r_stat_refresh_count + 1'b1;
      end
      if (w_debt_next > r_stat_max_debt) begin
        r_stat_max_debt <= w_debt_next;
      end
    end
  end

  assign o_stat_refresh_count = r_stat_refresh_count;
  assign o_stat_max_debt      = r_stat_max_debt;
`else
  assign o_stat_refresh_count = '0;
  assign o_stat_max_debt      = '0;
`endif

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for the SDRAM refresh scheduler using default parameters.
// Edge numbers below count rising clock edges since enable was first raised.
module tb_sdram_refresh_sched;

  localparam int DW = 4;

`ifdef SDRAM_REFSCHED_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_enable;
  logic          i_client_active;
  logic          i_refresh_ack;
  logic          o_refresh_req;
  logic          o_hold_clients;
  logic [DW-1:0] o_debt;
  logic          o_overflow;
  logic [15:0]   o_stat_refresh_count;
  logic [DW-1:0] o_stat_max_debt;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;

  sdram_refresh_sched dut (
    .clk                  (clk),
    .reset                (reset),
    .i_enable             (i_enable),
    .i_client_active      (i_client_active),
    .i_refresh_ack        (i_refresh_ack),
    .o_refresh_req        (o_refresh_req),
    .o_hold_clients       (o_hold_clients),
    .o_debt               (o_debt),
    .o_overflow           (o_overflow),
    .o_stat_refresh_count (o_stat_refresh_count),
    .o_stat_max_debt      (o_stat_max_debt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, n_edges);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_edges++;
  endtask

  task automatic goto(input int e);
    while (n_edges < e) step();
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS_ON ? v : 32'd0;
  endfunction

  task automatic chk_zero_state(input string tag);
    chk({tag, "_debt"},  32'(o_debt),               0);
    chk({tag, "_req"},   32'(o_refresh_req),        0);
    chk({tag, "_hold"},  32'(o_hold_clients),       0);
    chk({tag, "_ovf"},   32'(o_overflow),           0);
    chk({tag, "_scnt"},  32'(o_stat_refresh_count), 0);
    chk({tag, "_smax"},  32'(o_stat_max_debt),      0);
  endtask

  initial begin
    reset           = 1'b1;
    i_enable        = 1'b0;
    i_client_active = 1'b0;
    i_refresh_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_state("reset");

    reset    = 1'b0;
    i_enable = 1'b1;
    n_edges  = 0;

    // First obligation lands on edge 1000; clients quiet so request follows
    goto(999);
    chk("pre_tick_debt", 32'(o_debt), 0);
    chk("pre_tick_req",  32'(o_refresh_req), 0);
    goto(1000);
    chk("tick1_debt", 32'(o_debt), 1);
    chk("tick1_req",  32'(o_refresh_req), 1);

    i_refresh_ack = 1'b1;
    step();                                   // 1001
    i_refresh_ack = 1'b0;
    chk("ack1_debt", 32'(o_debt), 0);
    chk("ack1_req",  32'(o_refresh_req), 0);

    // Busy clients: debt climbs, urgent path at 6 (tick on edge 7000)
    i_client_active = 1'b1;
    goto(6999);
    chk("busy5_debt", 32'(o_debt), 5);
    chk("busy5_hold", 32'(o_hold_clients), 0);
    chk("busy5_req",  32'(o_refresh_req), 0);
    goto(7000);
    chk("urg_debt", 32'(o_debt), 6);
    chk("urg_hold", 32'(o_hold_clients), 1);
    chk("urg_req",  32'(o_refresh_req), 1);

    i_refresh_ack = 1'b1;
    step();                                   // 7001
    i_refresh_ack = 1'b0;
    chk("urg_exit_debt", 32'(o_debt), 5);
    chk("urg_exit_hold", 32'(o_hold_clients), 0);
    chk("urg_exit_req",  32'(o_refresh_req), 0);

    // Quiet again: opportunistic request, pay down to 2, then withdraw
    i_client_active = 1'b0;
    goto(7030);
    chk("opp_req",  32'(o_refresh_req), 1);
    chk("opp_hold", 32'(o_hold_clients), 0);
    i_refresh_ack = 1'b1;
    goto(7033);
    i_refresh_ack = 1'b0;
    chk("opp_paid_debt", 32'(o_debt), 2);
    chk("opp_paid_req",  32'(o_refresh_req), 1);
    i_client_active = 1'b1;
    step();                                   // 7034
    i_client_active = 1'b0;
    chk("withdraw_req",  32'(o_refresh_req), 0);
    chk("withdraw_debt", 32'(o_debt), 2);

    // Tick on 8000 -> 3; tick and ack together on 9000 leave it at 3
    goto(8500);
    chk("pre_coinc_debt", 32'(o_debt), 3);
    chk("pre_coinc_req",  32'(o_refresh_req), 1);
    goto(8999);
    i_refresh_ack = 1'b1;
    step();                                   // 9000
    chk("coinc_debt", 32'(o_debt), 3);
    goto(9003);
    chk("drain_debt", 32'(o_debt), 0);
    chk("drain_req",  32'(o_refresh_req), 0);
    step();                                   // 9004: ack with nothing owed
    i_refresh_ack = 1'b0;
    chk("spur_debt", 32'(o_debt), 0);
    chk("spur_req",  32'(o_refresh_req), 0);
    chk("spur_scnt", 32'(o_stat_refresh_count), st(9));
    chk("spur_smax", 32'(o_stat_max_debt), st(6));

    // Nine unpaid ticks (10000..18000): saturate at 8 then overflow
    goto(16999);
    chk("sat7_debt", 32'(o_debt), 7);
    goto(17999);
    chk("sat8_debt", 32'(o_debt), 8);
    chk("sat8_hold", 32'(o_hold_clients), 1);
    chk("sat8_ovf",  32'(o_overflow), 0);
    goto(18000);
    chk("ovf_debt", 32'(o_debt), 8);
    chk("ovf_flag", 32'(o_overflow), 1);

    // Dormant for one edge: debt and outputs clear, overflow sticks
    i_enable = 1'b0;
    step();                                   // 18001
    i_enable = 1'b1;
    chk("dis_debt", 32'(o_debt), 0);
    chk("dis_req",  32'(o_refresh_req), 0);
    chk("dis_hold", 32'(o_hold_clients), 0);
    chk("dis_ovf",  32'(o_overflow), 1);

    // Timer restarted: next tick exactly 1000 edges after re-enable
    goto(19000);
    chk("reen_pre_debt", 32'(o_debt), 0);
    goto(19001);
    chk("reen_debt", 32'(o_debt), 1);
    chk("reen_req",  32'(o_refresh_req), 1);
    chk("reen_ovf",  32'(o_overflow), 1);
    chk("reen_scnt", 32'(o_stat_refresh_count), st(9));
    chk("reen_smax", 32'(o_stat_max_debt), st(8));

    // Reset mid-operation clears everything including overflow and stats
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_refresh_sched.md
Name: sdram_refresh_sched

Overview:
- Owns the refresh budget for the 3-channel byte SDRAM controller.
- Accrues one refresh obligation every REFI_CYCLES and pays it off opportunistically while clients are quiet.
- When debt becomes urgent, stalls clients so refresh wins the controller's lowest-priority slot.
- Sits between the core clock domain's client request logic and the controller's refresh/ack pins.

Parameters:
REFI_CYCLES, 1000, clk cycles per refresh obligation (7.8 us at ~128 MHz)
MAX_DEBT, 8, debt saturation value; a tick at MAX_DEBT sets overflow
URGENT_THRESH, 6, debt at or above which the urgent path engages
IDLE_WIN, 16, consecutive quiet cycles required before an opportunistic refresh
DEBT_W, $clog2(MAX_DEBT+1), debt width (derived, not overridden)

Ports:
clk  in  1  controller clock
reset  in  1  synchronous, active-high
enable  in  1  0 during controller init sequence; scheduler dormant
client_active  in  1  OR of all channel rd/wr/busy
refresh_ack  in  1  one-cycle pulse from controller when it issues AUTO_REFRESH
refresh_req  out  1  level request to controller refresh input
hold_clients  out  1  blocks new channel requests upstream
debt  out  DEBT_W  outstanding refresh obligations
overflow  out  1  sticky: obligation lost
stat_refresh_count  out  16  acks consumed (feature-gated)
stat_max_debt  out  DEBT_W  peak debt seen (feature-gated)

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset: state S_IDLE. tick_cnt=0, idle_cnt=0, debt=0. refresh_req=0, hold_clients=0, overflow=0, stats=0.
- tick_cnt counts 0..REFI_CYCLES-1. tick is a 1-cycle pulse on wrap.
- idle_cnt counts cycles with client_active=0 and saturates at IDLE_WIN. It clears on any client_active=1. idle_ok = (idle_cnt==IDLE_WIN).
- Debt update:
  - tick only: +1.
  - ack with debt>0: -1.
  - tick and ack in the same cycle: unchanged.
  - ack with debt==0: ignored; no underflow, not counted.
  - tick with debt==MAX_DEBT: debt stays MAX_DEBT; overflow set until reset.
- States:
  - S_IDLE: req=0, hold=0. Goes to S_URG if debt_next>=URGENT_THRESH. Otherwise goes to S_OPP if debt_next>0 and idle_ok.
  - S_OPP: req=1, hold=0.
    - ack with debt_next==0 -> S_IDLE.
    - client_active=1 with no ack and debt_next<URGENT_THRESH -> S_IDLE (request withdrawn).
    - debt_next>=URGENT_THRESH -> S_URG.
    - Otherwise remain.
    - If ack and client_active arrive in the same cycle, ack takes effect first, then the client_active rule applies.
  - S_URG: req=1, hold=1. Leaves to S_IDLE when debt_next<URGENT_THRESH. Otherwise remains.
- Outputs are registered from next-state/debt_next. refresh_req falls the cycle after the ack that zeroes debt; the controller's multi-cycle access window guarantees no duplicate refresh.
- hold_clients asserts the cycle after debt reaches URGENT_THRESH. In-flight channel accesses complete normally.
- enable=0: forces S_IDLE. tick_cnt, idle_cnt and debt clear; req=0, hold=0. overflow and stats retained. The controller refreshes during its own init.
- Reset mid-operation: reset values on the next edge regardless of state.

Optional Feature:
SDRAM_REFSCHED_STATS_EN
- Defined:
  - stat_refresh_count increments (wrapping at 16 bits) on every consumed ack.
  - stat_max_debt tracks the peak of debt.
  - Both are cleared only by reset.
- Undefined: both outputs are constant 0 and no counter logic is generated.

Decomposition:
- Package sdram_pkg holds:
  - state enum (S_IDLE, S_OPP, S_URG)
  - controller command constants shared with the SDRAM controller
  - default REFI_CYCLES/MAX_DEBT values
- One natural sub-module: sdram_refresh_timer, containing tick_cnt and the tick pulse, reusable for other tREFI-derived timing.
- Debt/state logic remains in the top.

Test Plan:
- Reset, enable=1, client_active=0, REFI_CYCLES=1000:
  - first tick at cycle 1000 -> debt=1.
  - refresh_req rises once idle_ok holds; ack -> debt=0, req low next cycle.
- client_active=1 held for 6000 cycles, no acks:
  - debt climbs 1..6; hold_clients=1 and req=1 the cycle after debt hits 6.
  - one ack -> debt=5 -> S_IDLE, hold=0.
- Opportunistic withdrawal: debt=2 in S_OPP, client_active pulses with no ack -> req=0 next cycle, debt unchanged at 2.
- tick and ack in the same cycle at debt=3 -> debt stays 3. Spurious ack at debt=0 -> debt 0, stat count unchanged.
- No acks for 9 ticks -> debt saturates at 8, overflow=1 sticky through enable toggling; cleared only by reset.
- SDRAM_REFSCHED_STATS_EN defined, 5 consumed acks with peak debt 4 -> stat_refresh_count=5, stat_max_debt=4. Undefined -> both 0.
